seg7_scan_capture: RTL

- Reader side of the team's 7-segment display path: it snoops a multiplexed, active-low 7-segment drive bus and recovers the hex value shown on each digit.
- Each digit pattern is qualified for stability, then decoded back to 4-bit binary, and flagged as valid, blank or illegal.
- Used in loopback self-test and board-level monitors, placed beside the display driver, with all logic on one clock.

---
 rtl/seg7_scan_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: snoops a multiplexed active-low 7-segment bus and
// recovers the hex value, valid and blank status shown on each digit.
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    update,
    output logic [3:0]              upd_digit,
    output logic                    err,
    output logic [1:0]              err_code
);
    localparam int unsigned IN_W  = NUM_DIGITS + 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned POP_W = 5;
    localparam logic [CNT_W-1:0] SETTLE_C    = CNT_W'(SETTLE);
    localparam logic [TMO_W-1:0] TIMEOUT_C   = TMO_W'(TIMEOUT);
    localparam logic [6:0]       SEG_BLANK   = 7'h7F;
    localparam logic [1:0]       ERR_ILLEGAL = 2'b01;
    localparam logic [1:0]       ERR_MULTI   = 2'b10;

    // Returns {legal, value}; legal=0 for any pattern outside the hex table.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h18:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [IN_W-1:0]         in_d, in_q, prev_d, prev_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    armed_d, armed_q;
    logic                    fresh_d, fresh_q;
    logic [4*NUM_DIGITS-1:0] hex_d, hex_q;
    logic [NUM_DIGITS-1:0]   valid_d, valid_q;
    logic [NUM_DIGITS-1:0]   blank_d, blank_q;
    logic                    update_d, update_q;
    logic [3:0]              upd_digit_d, upd_digit_q;
    logic                    err_d, err_q;
    logic [1:0]              err_code_d, err_code_q;
    logic [TMO_W-1:0]        tmo_d [NUM_DIGITS];
    logic [TMO_W-1:0]        tmo_q [NUM_DIGITS];

    logic                    changed_c;
    logic                    decide_c;
    logic [NUM_DIGITS-1:0]   win_en_c;
    logic [6:0]              win_seg_c;
    logic [4:0]              dec_c;
    logic [POP_W-1:0]        en_cnt_c;
    logic [3:0]              en_idx_c;

    // Input capture and one-cycle history used for change detection.
    always_comb begin
        in_d   = {dig_en, seg};
        prev_d = in_q;
    end

    // Stable-window content: select population, selected index, decode.
    always_comb begin
        win_en_c  = prev_q[IN_W-1:7];
        win_seg_c = prev_q[6:0];
        dec_c     = seg_decode(win_seg_c);
        en_cnt_c  = '0;
        en_idx_c  = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            en_cnt_c = en_cnt_c + POP_W'(win_en_c[d]);
            if (win_en_c[d]) begin
                en_idx_c = 4'(d);
            end
        end
    end

    // Run counter and arming; fresh forces the first post-reset sample to count as a change.
    always_comb begin
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        fresh_d   = 1'b0;
        changed_c = fresh_q || (in_q != prev_q);
        decide_c  = armed_q && (cnt_q >= SETTLE_C);
        if (decide_c) begin
            armed_d = 1'b0;
        end
        if (changed_c) begin
            cnt_d   = CNT_W'(1);
            armed_d = 1'b1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Per-digit timeout aging, then commit/error resolution (commit overrides timeout).
    always_comb begin
        hex_d       = hex_q;
        valid_d     = valid_q;
        blank_d     = blank_q;
        update_d    = 1'b0;
        upd_digit_d = '0;
        err_d       = 1'b0;
        err_code_d  = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            tmo_d[d] = (tmo_q[d] == '1) ? tmo_q[d] : tmo_q[d] + TMO_W'(1);
            if ((TIMEOUT_C != '0) && (tmo_d[d] >= TIMEOUT_C)) begin
                valid_d[d] = 1'b0;
                blank_d[d] = 1'b0;
            end
        end
        if (decide_c) begin
            if (en_cnt_c > POP_W'(1)) begin
                err_d      = 1'b1;
                err_code_d = ERR_MULTI;
            end else if (en_cnt_c == POP_W'(1)) begin
                if ((win_seg_c == SEG_BLANK) || dec_c[4]) begin
                    update_d    = 1'b1;
                    upd_digit_d = en_idx_c;
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (win_en_c[d]) begin
                            hex_d[4*d +: 4] = dec_c[3:0];
                            valid_d[d]      = dec_c[4];
                            blank_d[d]      = ~dec_c[4];
                            tmo_d[d]        = '0;
                        end
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                end
            end
        end
    end

    // Input stage: contents carry no reset.
    always_ff @(posedge clk) begin
        in_q   <= in_d;
        prev_q <= prev_d;
    end

    // Run-counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            fresh_q <= fresh_d;
        end
    end

    // Registered outputs and timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q       <= '0;
            valid_q     <= '0;
            blank_q     <= '0;
            update_q    <= 1'b0;
            upd_digit_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                tmo_q[d] <= '0;
            end
        end else begin
            hex_q       <= hex_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            update_q    <= update_d;
            upd_digit_q <= upd_digit_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                tmo_q[d] <= tmo_d[d];
            end
        end
    end

    assign hex       = hex_q;
    assign valid     = valid_q;
    assign blank     = blank_q;
    assign update    = update_q;
    assign upd_digit = upd_digit_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
